// File: rtl/can_bit_destuffer.sv
// -----------------------------------------------------------------------------
// can_bit_destuffer
//
// Purpose:
//   Sits between the CAN bit-synchroniser and the frame/ID decoder. It turns
//   the sample strobes of each bit period into one logical bit. It tracks bus
//   idle, detects start of frame and removes stuff bits from the frame. A
//   stuffing violation is flagged as a stuff error.
//
// Ports:
//   clk            in   system clock
//   resetN         in   asynchronous active-low reset
//   syncIn         in   synchronised CAN line (1 = recessive)
//   syncCANClk     in   bit-period reference level; rising edge closes a bit
//   oneShotSample  in   single-cycle sample strobe
//   multiSelect    in   1 = three-sample majority mode
//   stuffDisable   in   high once the CRC field is complete (no more stuffing)
//   bitOut         out  destuffed bit value, qualified by bitValid
//   bitValid       out  one-cycle pulse qualifying bitOut
//   sof            out  one-cycle start-of-frame pulse (with first bitValid)
//   stuffErr       out  one-cycle stuff-violation pulse
//   busIdle        out  level, high while the bus is idle
//   inFrame        out  level, high during frame body and tail
//   dbgState       out  current FSM state encoding (debug observation)
//
// Optional build macro CAN_DESTUFF_STATS_EN adds:
//   statsClear     in   synchronous clear of both statistics counters
//   stuffBitCount  out  saturating count of stuff bits removed
//   stuffErrCount  out  saturating count of stuff errors
//
// Handshake: bitValid is a pure strobe with no back-pressure. The consumer
// must take bitOut in every cycle where bitValid is high. bitOut holds its
// last value otherwise.
// -----------------------------------------------------------------------------
module can_bit_destuffer #(
   parameter int IDLE_BITS = 11,
   parameter int STUFF_LEN = 5,
   parameter int TAIL_BITS = 7
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        syncIn,
   input  logic        syncCANClk,
   input  logic        oneShotSample,
   input  logic        multiSelect,
   input  logic        stuffDisable,
`ifdef CAN_DESTUFF_STATS_EN
   input  logic        statsClear,
   output logic [15:0] stuffBitCount,
   output logic [15:0] stuffErrCount,
`endif
   output logic        bitOut,
   output logic        bitValid,
   output logic        sof,
   output logic        stuffErr,
   output logic        busIdle,
   output logic        inFrame,
   output logic [2:0]  dbgState
);

   localparam logic [3:0] IDLE_W  = 4'(IDLE_BITS);
   localparam logic [3:0] TAIL_W  = 4'(TAIL_BITS);
   localparam logic [2:0] STUFF_W = 3'(STUFF_LEN);

   typedef enum logic [2:0] {
      ST_HUNT  = 3'd0,
      ST_IDLE  = 3'd1,
      ST_FRAME = 3'd2,
      ST_TAIL  = 3'd3,
      ST_ERROR = 3'd4
   } state_t;

   state_t      state_q;
   logic        cclk_q;
   logic [1:0]  samp_cnt_q, samp_cnt_d;
   logic [2:0]  slot_q, slot_d;
   logic [3:0]  idle_cnt_q, tail_cnt_q;
   logic [3:0]  idle_inc_d, tail_inc_d;
   logic        run_val_q;
   logic [2:0]  run_len_q;
   logic        bit_out_q, bit_valid_q, sof_q, stuff_err_q, bus_idle_q, in_frame_q;

   logic        boundary;
   logic        bit_rdy;
   logic        bit_val;
   logic        majority;

   // A bit closes on the rising edge of the bit-period level. A boundary
   // with no strobes collected carries no information and is skipped.
   assign boundary = syncCANClk & ~cclk_q;
   assign bit_rdy  = boundary & (samp_cnt_q != 2'd0);
   assign majority = (slot_q[0] & slot_q[1]) | (slot_q[0] & slot_q[2]) |
                     (slot_q[1] & slot_q[2]);
   assign bit_val  = (multiSelect && samp_cnt_q == 2'd3) ? majority : slot_q[0];

   // Saturating increments for the recessive-run counters.
   assign idle_inc_d = (idle_cnt_q == 4'hF) ? 4'hF : idle_cnt_q + 4'd1;
   assign tail_inc_d = (tail_cnt_q == 4'hF) ? 4'hF : tail_cnt_q + 4'd1;

   // Sample slots. A strobe coinciding with the boundary starts the next bit.
   always_comb begin
      samp_cnt_d = samp_cnt_q;
      slot_d     = slot_q;
      if (boundary) begin
         samp_cnt_d = 2'd0;
      end
      if (oneShotSample) begin
         if (boundary) begin
            slot_d[0]  = syncIn;
            samp_cnt_d = 2'd1;
         end else if (samp_cnt_q != 2'd3) begin
            slot_d[samp_cnt_q] = syncIn;
            samp_cnt_d         = samp_cnt_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         cclk_q     <= 1'b0;
         samp_cnt_q <= 2'd0;
         slot_q     <= 3'd0;
      end else begin
         cclk_q     <= syncCANClk;
         samp_cnt_q <= samp_cnt_d;
         slot_q     <= slot_d;
      end
   end

   // Bit-level FSM. All outputs are registered here. Pulses default low.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q     <= ST_HUNT;
         idle_cnt_q  <= 4'd0;
         tail_cnt_q  <= 4'd0;
         run_val_q   <= 1'b0;
         run_len_q   <= 3'd0;
         bit_out_q   <= 1'b0;
         bit_valid_q <= 1'b0;
         sof_q       <= 1'b0;
         stuff_err_q <= 1'b0;
         bus_idle_q  <= 1'b0;
         in_frame_q  <= 1'b0;
      end else begin
         bit_valid_q <= 1'b0;
         sof_q       <= 1'b0;
         stuff_err_q <= 1'b0;
         case (state_q)
            ST_HUNT: begin
               if (bit_rdy) begin
                  if (bit_val) begin
                     idle_cnt_q <= idle_inc_d;
                     if (idle_inc_d >= IDLE_W) begin
                        state_q    <= ST_IDLE;
                        bus_idle_q <= 1'b1;
                     end
                  end else begin
                     idle_cnt_q <= 4'd0;
                  end
               end
            end
            ST_IDLE: begin
               if (bit_rdy && !bit_val) begin
                  sof_q       <= 1'b1;
                  bit_valid_q <= 1'b1;
                  bit_out_q   <= 1'b0;
                  run_val_q   <= 1'b0;
                  run_len_q   <= 3'd1;
                  bus_idle_q  <= 1'b0;
                  in_frame_q  <= 1'b1;
                  state_q     <= ST_FRAME;
               end
            end
            ST_FRAME: begin
               if (bit_rdy) begin
                  if (stuffDisable) begin
                     // Past the CRC: stop destuffing, bit passes raw.
                     state_q     <= ST_TAIL;
                     bit_valid_q <= 1'b1;
                     bit_out_q   <= bit_val;
                     tail_cnt_q  <= {3'd0, bit_val};
                  end else if (run_len_q == STUFF_W) begin
                     if (bit_val != run_val_q) begin
                        // Stuff bit: dropped, but it seeds the next run.
                        run_val_q <= bit_val;
                        run_len_q <= 3'd1;
                     end else begin
                        stuff_err_q <= 1'b1;
                        in_frame_q  <= 1'b0;
                        state_q     <= ST_ERROR;
                     end
                  end else begin
                     bit_valid_q <= 1'b1;
                     bit_out_q   <= bit_val;
                     if (bit_val == run_val_q) begin
                        run_len_q <= run_len_q + 3'd1;
                     end else begin
                        run_val_q <= bit_val;
                        run_len_q <= 3'd1;
                     end
                  end
               end
            end
            ST_TAIL: begin
               if (bit_rdy) begin
                  bit_valid_q <= 1'b1;
                  bit_out_q   <= bit_val;
                  if (bit_val) begin
                     tail_cnt_q <= tail_inc_d;
                     if (tail_inc_d == TAIL_W) begin
                        // EOF recessive bits already count toward bus idle.
                        state_q    <= ST_HUNT;
                        idle_cnt_q <= TAIL_W;
                        in_frame_q <= 1'b0;
                     end
                  end else begin
                     tail_cnt_q <= 4'd0;
                  end
               end
            end
            ST_ERROR: begin
               state_q    <= ST_HUNT;
               idle_cnt_q <= 4'd0;
            end
            default: begin
               state_q <= ST_HUNT;
            end
         endcase
      end
   end

`ifdef CAN_DESTUFF_STATS_EN
   logic        stuff_bit_evt, stuff_err_evt;
   logic [15:0] stuff_bit_cnt_q, stuff_err_cnt_q;

   assign stuff_bit_evt = (state_q == ST_FRAME) && bit_rdy && !stuffDisable &&
                          (run_len_q == STUFF_W) && (bit_val != run_val_q);
   assign stuff_err_evt = (state_q == ST_FRAME) && bit_rdy && !stuffDisable &&
                          (run_len_q == STUFF_W) && (bit_val == run_val_q);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         stuff_bit_cnt_q <= 16'd0;
         stuff_err_cnt_q <= 16'd0;
      end else if (statsClear) begin
         stuff_bit_cnt_q <= 16'd0;
         stuff_err_cnt_q <= 16'd0;
      end else begin
         if (stuff_bit_evt && stuff_bit_cnt_q != 16'hFFFF) begin
            stuff_bit_cnt_q <= stuff_bit_cnt_q + 16'd1;
         end
         if (stuff_err_evt && stuff_err_cnt_q != 16'hFFFF) begin
            stuff_err_cnt_q <= stuff_err_cnt_q + 16'd1;
         end
      end
   end

   assign stuffBitCount = stuff_bit_cnt_q;
   assign stuffErrCount = stuff_err_cnt_q;
`endif

   assign bitOut   = bit_out_q;
   assign bitValid = bit_valid_q;
   assign sof      = sof_q;
   assign stuffErr = stuff_err_q;
   assign busIdle  = bus_idle_q;
   assign inFrame  = in_frame_q;
   assign dbgState = state_q;

endmodule

// File: tb/tb_can_bit_destuffer.sv
// -----------------------------------------------------------------------------
// tb_can_bit_destuffer
//
// Directed bench for can_bit_destuffer. It contains a bus-level reference
// model. The model keeps the raw frame history since SOF and scans it for the
// trailing run length. It also counts trailing recessive bits for idle and EOF
// detection. A per-cycle compare process checks the DUT against the model. An
// expected queue holds the bitOut values. Literal checks pin the model to
// hand-derived results.
// -----------------------------------------------------------------------------
module tb_can_bit_destuffer;

   localparam int IDLE_BITS = 11;
   localparam int STUFF_LEN = 5;
   localparam int TAIL_BITS = 7;

   localparam int M_HUNT  = 0;
   localparam int M_IDLE  = 1;
   localparam int M_FRAME = 2;
   localparam int M_TAIL  = 3;

   // ---------------- clock / reset / DUT ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       resetN, syncIn, syncCANClk, oneShotSample, multiSelect, stuffDisable;
   logic       bitOut, bitValid, sof, stuffErr, busIdle, inFrame;
   logic [2:0] dbgState;

   can_bit_destuffer #(
      .IDLE_BITS(IDLE_BITS), .STUFF_LEN(STUFF_LEN), .TAIL_BITS(TAIL_BITS)
   ) dut (
      .clk(clk), .resetN(resetN), .syncIn(syncIn), .syncCANClk(syncCANClk),
      .oneShotSample(oneShotSample), .multiSelect(multiSelect),
      .stuffDisable(stuffDisable), .bitOut(bitOut), .bitValid(bitValid),
      .sof(sof), .stuffErr(stuffErr), .busIdle(busIdle), .inFrame(inFrame),
      .dbgState(dbgState)
   );

   // ---------------- scoreboard state ----------------
   int   checks = 0;
   int   errors = 0;
   logic chk_on = 1'b0;
   logic [0:0] exp_q[$];
   logic exp_valid, exp_sof, exp_err, exp_idle, exp_frame;

   // Observations for the literal checks.
   int   n_valid, n_sof, n_err;
   logic obs_bits[$];

   // ---------------- reference model ----------------
   int   mode;
   logic hist[$];
   int   idle_run, tail_run;
   logic prev_cclk;
   logic samp[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      mode = M_HUNT;
      hist.delete();
      samp.delete();
      idle_run  = 0;
      tail_run  = 0;
      prev_cclk = 1'b0;
      exp_valid = 1'b0;
      exp_sof   = 1'b0;
      exp_err   = 1'b0;
      exp_idle  = 1'b0;
      exp_frame = 1'b0;
   endtask

   // Count the identical bits at the end of the raw frame history.
   function automatic int trailing_run();
      int   n;
      logic last;
      n    = 1;
      last = hist[hist.size()-1];
      for (int i = hist.size() - 2; i >= 0; i--) begin
         if (hist[i] != last) break;
         n++;
      end
      return n;
   endfunction

   task automatic model_bit(input logic b);
      case (mode)
         M_HUNT: begin
            idle_run = b ? ((idle_run < 15) ? idle_run + 1 : 15) : 0;
            if (idle_run >= IDLE_BITS) begin
               mode     = M_IDLE;
               exp_idle = 1'b1;
            end
         end
         M_IDLE: begin
            if (!b) begin
               mode = M_FRAME;
               hist.delete();
               hist.push_back(1'b0);
               exp_valid = 1'b1;
               exp_sof   = 1'b1;
               exp_q.push_back(1'b0);
               exp_idle  = 1'b0;
               exp_frame = 1'b1;
            end
         end
         M_FRAME: begin
            if (stuffDisable) begin
               mode      = M_TAIL;
               tail_run  = b ? 1 : 0;
               exp_valid = 1'b1;
               exp_q.push_back(b);
            end else if (trailing_run() >= STUFF_LEN) begin
               if (b != hist[hist.size()-1]) begin
                  hist.push_back(b);
               end else begin
                  exp_err   = 1'b1;
                  exp_frame = 1'b0;
                  mode      = M_HUNT;
                  idle_run  = 0;
               end
            end else begin
               hist.push_back(b);
               exp_valid = 1'b1;
               exp_q.push_back(b);
            end
         end
         default: begin
            exp_valid = 1'b1;
            exp_q.push_back(b);
            tail_run = b ? tail_run + 1 : 0;
            if (tail_run == TAIL_BITS) begin
               mode      = M_HUNT;
               idle_run  = TAIL_BITS;
               exp_frame = 1'b0;
            end
         end
      endcase
   endtask

   task automatic model_cycle(input logic s, input logic stb, input logic cc);
      logic bnd;
      int   ones;
      logic b;
      bnd       = cc && !prev_cclk;
      prev_cclk = cc;
      if (bnd) begin
         if (samp.size() > 0) begin
            if (multiSelect && samp.size() == 3) begin
               ones = 0;
               foreach (samp[i]) if (samp[i]) ones++;
               b = (ones >= 2);
            end else begin
               b = samp[0];
            end
            model_bit(b);
         end
         samp.delete();
      end
      if (stb && samp.size() < 3) samp.push_back(s);
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input logic s, input logic stb, input logic cc);
      syncIn        = s;
      oneShotSample = stb;
      syncCANClk    = cc;
      @(posedge clk);
      #1;
      exp_valid = 1'b0;
      exp_sof   = 1'b0;
      exp_err   = 1'b0;
      if (resetN) model_cycle(s, stb, cc);
   endtask

   // One bit period: up to three strobes with v[0] first, a quiet cycle, then the
   // boundary. An optional strobe on the boundary cycle belongs to the next bit.
   task automatic send_bit(input logic [2:0] v, input int n, input logic late, input logic late_v);
      for (int i = 0; i < 3; i++) step(v[i], (i < n), 1'b0);
      step(v[0], 1'b0, 1'b0);
      step(late_v, late, 1'b1);
      step(v[0], 1'b0, 1'b1);
      step(v[0], 1'b0, 1'b1);
   endtask

   task automatic send1(input logic b);
      send_bit({b, b, b}, 1, 1'b0, 1'b0);
   endtask

   task automatic clear_obs();
      n_valid = 0;
      n_sof   = 0;
      n_err   = 0;
      obs_bits.delete();
   endtask

   function automatic logic [31:0] packed_obs();
      logic [31:0] v;
      v = 32'd0;
      foreach (obs_bits[i]) v = {v[30:0], obs_bits[i]};
      return v;
   endfunction

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (chk_on) begin
         chk("bitValid", {31'd0, bitValid}, {31'd0, exp_valid});
         chk("sof", {31'd0, sof}, {31'd0, exp_sof});
         chk("stuffErr", {31'd0, stuffErr}, {31'd0, exp_err});
         chk("busIdle", {31'd0, busIdle}, {31'd0, exp_idle});
         chk("inFrame", {31'd0, inFrame}, {31'd0, exp_frame});
         if (bitValid === 1'b1) begin
            n_valid++;
            obs_bits.push_back(bitOut);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL bitOut_unexpected actual=%0b required=none", bitOut);
            end else begin
               chk("bitOut", {31'd0, bitOut}, {31'd0, exp_q.pop_front()});
            end
         end
         if (sof === 1'b1) n_sof++;
         if (stuffErr === 1'b1) n_err++;
      end
   end

   // ---------------- stimulus ----------------
   logic [15:0] body;

   initial begin
      resetN        = 1'b0;
      syncIn        = 1'b1;
      syncCANClk    = 1'b0;
      oneShotSample = 1'b0;
      multiSelect   = 1'b0;
      stuffDisable  = 1'b0;
      model_reset();
      clear_obs();
      step(1'b1, 1'b0, 1'b0);
      chk_on = 1'b1;
      step(1'b1, 1'b0, 1'b0);
      chk("rst_outputs", {26'd0, bitOut, bitValid, sof, stuffErr, busIdle, inFrame}, 32'd0);
      resetN = 1'b1;

      // 11 recessive bits declare the bus idle; nothing is passed on.
      repeat (10) send1(1'b1);
      chk("idle_before_11th", {31'd0, busIdle}, 32'd0);
      send1(1'b1);
      chk("idle_after_11th", {31'd0, busIdle}, 32'd1);
      chk("hunt_no_valid", n_valid, 32'd0);

      // SOF, four more dominant bits, stuff bit, one recessive data bit.
      clear_obs();
      send1(1'b0); send1(1'b0); send1(1'b0); send1(1'b0); send1(1'b0);
      send1(1'b1); send1(1'b1);
      chk("frame_valid_count", n_valid, 32'd6);
      chk("frame_sof_count", n_sof, 32'd1);
      chk("frame_bits", packed_obs(), 32'h01);
      chk("frame_inFrame", {31'd0, inFrame}, 32'd1);

      // Stuff bit plus four recessive bits: a sixth recessive bit is a violation.
      clear_obs();
      send1(1'b1); send1(1'b1); send1(1'b1);
      chk("run_valid_count", n_valid, 32'd3);
      send1(1'b1);
      chk("stuff_err_count", n_err, 32'd1);
      chk("err_inFrame", {31'd0, inFrame}, 32'd0);
      chk("err_no_extra_valid", n_valid, 32'd3);

      // Back to idle, then majority sampling.
      repeat (11) send1(1'b1);
      chk("idle_after_err", {31'd0, busIdle}, 32'd1);
      clear_obs();
      multiSelect = 1'b1;
      send_bit(3'b000, 1, 1'b0, 1'b0);  // SOF, single sample
      send_bit(3'b110, 3, 1'b0, 1'b0);  // samples 0,1,1 -> 1
      send_bit(3'b001, 2, 1'b0, 1'b0);  // samples 1,0   -> slot0 = 1
      send_bit(3'b001, 3, 1'b0, 1'b0);  // samples 1,0,0 -> 0
      multiSelect = 1'b0;
      chk("multi_bits", packed_obs(), 32'h6);
      chk("multi_sof", n_sof, 32'd1);

      // 16 more body bits, making 20 frame bits, then 7 raw recessive EOF bits.
      body = 16'b0011_0100_1110_0010;
      for (int i = 15; i >= 0; i--) send1(body[i]);
      stuffDisable = 1'b1;
      clear_obs();
      repeat (6) send1(1'b1);
      chk("tail_inFrame_6", {31'd0, inFrame}, 32'd1);
      send1(1'b1);
      chk("tail_valid_count", n_valid, 32'd7);
      chk("tail_inFrame_7", {31'd0, inFrame}, 32'd0);
      repeat (3) send1(1'b1);
      chk("idle_after_tail_3", {31'd0, busIdle}, 32'd0);
      send1(1'b1);
      chk("idle_after_tail_4", {31'd0, busIdle}, 32'd1);
      stuffDisable = 1'b0;

      // stuffDisable on a bit that would be a stuff bit: passed raw.
      clear_obs();
      repeat (5) send1(1'b0);
      stuffDisable = 1'b1;
      send1(1'b1);
      chk("disable_wins_count", n_valid, 32'd6);
      chk("disable_wins_bits", packed_obs(), 32'h01);
      repeat (6) send1(1'b1);
      chk("disable_tail_end", {31'd0, inFrame}, 32'd0);
      repeat (4) send1(1'b1);
      stuffDisable = 1'b0;

      // Empty bit period, then a strobe on the boundary cycle seeding the next bit.
      clear_obs();
      send_bit(3'b111, 0, 1'b0, 1'b0);
      chk("empty_boundary", n_valid, 32'd0);
      send_bit(3'b111, 1, 1'b1, 1'b0);
      chk("late_strobe_no_sof", n_sof, 32'd0);
      send_bit(3'b111, 0, 1'b0, 1'b0);
      chk("late_strobe_sof", n_sof, 32'd1);

      // Asynchronous reset between strobes of a partial bit.
      send1(1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk("pre_reset_inFrame", {31'd0, inFrame}, 32'd1);
      #2;
      resetN = 1'b0;
      model_reset();
      exp_q.delete();
      #1;
      chk("async_reset_outputs", {26'd0, bitOut, bitValid, sof, stuffErr, busIdle, inFrame}, 32'd0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      resetN = 1'b1;
      clear_obs();
      repeat (10) send1(1'b1);
      send1(1'b0);
      chk("post_reset_no_early_sof", n_sof, 32'd0);
      repeat (11) send1(1'b1);
      chk("post_reset_idle", {31'd0, busIdle}, 32'd1);
      send1(1'b0);
      chk("post_reset_sof", n_sof, 32'd1);

      step(1'b1, 1'b0, 1'b0);
      chk("exp_q_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
